// File: rtl/wb_wrbuf_pkg.sv
// Shared definitions for the posted-write buffer: master FSM states and write-FIFO entry layout.
// No logic; no latency; no backpressure.
// Entry layout is {adr, sel, dat} with dat in the least-significant bits.
package wb_wrbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_WAIT  = 2'd3
    } mst_state_e;

    function automatic int ent_sel_lsb(input int width);
        return width;
    endfunction

    function automatic int ent_adr_lsb(input int width);
        return width + width / 8;
    endfunction

    function automatic int ent_width(input int width, input int address);
        return address + width / 8 + width;
    endfunction

endpackage

// File: rtl/wb_wrbuf_fifo.sv
// Register-based write FIFO; head entry is visible combinationally on dat_o.
// Latency: a pushed entry becomes the head one cycle after the push edge.
// Backpressure: pushes are ignored while full, pops ignored while empty.
module wb_wrbuf_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]          mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wptr_q, rptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_BITS + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dat_o   = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it until a push has written it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= dat_i;
    end

endmodule

// File: rtl/wb_wrbuf.sv
// Wishbone posted-write buffer: writes are acked into a FIFO and drained downstream; reads pass through once drained.
// Latency: write ack 1 cycle after s_stb_i; read ack 1 cycle after m_ack_i (>= 2 cycles round trip).
// Backpressure: writes stall while the FIFO is full, or get s_rty_o when WB_WRBUF_RTY_EN is defined.
module wb_wrbuf
    import wb_wrbuf_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDRESS    = 25,
    parameter int DEPTH_BITS = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               s_cyc_i,
    input  logic               s_stb_i,
    input  logic               s_we_i,
    input  logic [ADDRESS-1:0] s_adr_i,
    input  logic [WIDTH/8-1:0] s_sel_i,
    input  logic [WIDTH-1:0]   s_dat_i,
    output logic               s_ack_o,
    output logic               s_rty_o,
    output logic               s_err_o,
    output logic [WIDTH-1:0]   s_dat_o,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    output logic               m_we_o,
    output logic [ADDRESS-1:0] m_adr_o,
    output logic [WIDTH/8-1:0] m_sel_o,
    output logic [WIDTH-1:0]   m_dat_o,
    input  logic               m_ack_i,
    input  logic               m_rty_i,
    input  logic               m_err_i,
    input  logic [WIDTH-1:0]   m_dat_i,
    output logic               wrerr_o
);
    localparam int SELW    = WIDTH / 8;
    localparam int ENTW    = ent_width(WIDTH, ADDRESS);
    localparam int SEL_LSB = ent_sel_lsb(WIDTH);
    localparam int ADR_LSB = ent_adr_lsb(WIDTH);

    mst_state_e         state_q, state_d, ret_q, ret_d;
    logic               s_ack_q, s_ack_d, s_err_q, s_err_d, wrerr_q, wrerr_d;
    logic [WIDTH-1:0]   s_dat_q, s_dat_d;
    logic [ADDRESS-1:0] rd_adr_q, rd_adr_d;
    logic [SELW-1:0]    rd_sel_q, rd_sel_d;
    logic               wr_req, rd_live, rd_req;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTW-1:0]    head;

    // The slave holds its strobe through our registered termination, so that cycle must not count as a new request.
    assign rd_live   = s_cyc_i && s_stb_i && !s_we_i;
    assign wr_req    = s_cyc_i && s_stb_i && s_we_i && !s_ack_q && !s_rty_o;
    assign rd_req    = rd_live && !s_ack_q && !s_err_q;
    assign fifo_push = wr_req && !fifo_full;

`ifdef WB_WRBUF_RTY_EN
    logic s_rty_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) s_rty_q <= 1'b0;
        else          s_rty_q <= wr_req && fifo_full;
    end
    assign s_rty_o = s_rty_q;
`else
    assign s_rty_o = 1'b0;
`endif

    wb_wrbuf_fifo #(
        .W          (ENTW),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (fifo_push),
        .dat_i   ({s_adr_i, s_sel_i, s_dat_i}),
        .pop_i   (fifo_pop),
        .dat_o   (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_IDLE;
            s_ack_q  <= 1'b0;
            s_err_q  <= 1'b0;
            wrerr_q  <= 1'b0;
            s_dat_q  <= '0;
            rd_adr_q <= '0;
            rd_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            s_ack_q  <= s_ack_d;
            s_err_q  <= s_err_d;
            wrerr_q  <= wrerr_d;
            s_dat_q  <= s_dat_d;
            rd_adr_q <= rd_adr_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        fifo_pop = 1'b0;
        s_ack_d  = fifo_push;
        s_err_d  = 1'b0;
        wrerr_d  = wrerr_q;
        s_dat_d  = s_dat_q;
        rd_adr_d = rd_adr_q;
        rd_sel_d = rd_sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WRITE;
                end else if (rd_req) begin
                    state_d  = ST_READ;
                    rd_adr_d = s_adr_i;
                    rd_sel_d = s_sel_i;
                end
            end
            ST_WRITE: begin
                if (m_ack_i) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end else if (m_err_i) begin
                    fifo_pop = 1'b1;
                    wrerr_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (m_rty_i) begin
                    ret_d   = ST_WRITE;
                    state_d = ST_WAIT;
                end
            end
            ST_READ: begin
                // An abandoned read still completes downstream but is not terminated upstream.
                if (m_ack_i) begin
                    s_dat_d = m_dat_i;
                    s_ack_d = fifo_push || rd_live;
                    state_d = ST_IDLE;
                end else if (m_err_i) begin
                    s_err_d = rd_live;
                    state_d = ST_IDLE;
                end else if (m_rty_i) begin
                    ret_d   = ST_READ;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ret_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = '0;
        m_sel_o = '0;
        m_dat_o = '0;
        if (state_q == ST_WRITE) begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_we_o  = 1'b1;
            m_adr_o = head[ADR_LSB +: ADDRESS];
            m_sel_o = head[SEL_LSB +: SELW];
            m_dat_o = head[WIDTH-1:0];
        end else if (state_q == ST_READ) begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_adr_o = rd_adr_q;
            m_sel_o = rd_sel_q;
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = s_dat_q;
    assign wrerr_o = wrerr_q;

endmodule

// File: doc/wb_wrbuf.md
WB_WRBUF -- requirements
Module: wb_wrbuf

Interface
REQ-001 Parameter WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDRESS, default 25, word-address width.
REQ-003 Parameter DEPTH_BITS, default 2, log2 of write-FIFO depth (default 4 entries).
REQ-004 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 s_cyc_i, s_stb_i, s_we_i  in  1 each  upstream slave-port request, driven by wb_sync b-side.
REQ-007 s_adr_i  in  ADDRESS; s_sel_i  in  WIDTH/8; s_dat_i  in  WIDTH  request address, byte selects, write data.
REQ-008 s_ack_o, s_rty_o, s_err_o  out  1 each  slave-port termination.
REQ-009 s_dat_o  out  WIDTH  read data, valid with s_ack_o.
REQ-010 m_cyc_o, m_stb_o, m_we_o  out  1 each; m_adr_o  out  ADDRESS; m_sel_o  out  WIDTH/8; m_dat_o  out  WIDTH  downstream master port.
REQ-011 m_ack_i, m_rty_i, m_err_i  in  1 each; m_dat_i  in  WIDTH  downstream termination and read data.
REQ-012 wrerr_o  out  1  sticky flag: a posted write was terminated with m_err_i.

Function
REQ-013 Slave-port write with FIFO not full: push {adr,sel,dat}; s_ack_o high for exactly one cycle, the cycle after s_stb_i is sampled (registered ack).
REQ-014 Fullness uses the registered count; a push is refused when full even if a pop occurs in the same cycle.
REQ-015 Write with FIFO full: no push, no ack; request stalls until a slot frees (unless WB_WRBUF_RTY_EN, REQ-026).
REQ-016 Slave-port read is forwarded only when FIFO empty and master FSM in IDLE; reads never overtake buffered writes.
REQ-017 Master FSM states IDLE, WRITE, READ, WAIT.
REQ-018 IDLE->WRITE when FIFO non-empty (priority over reads); IDLE->READ when FIFO empty and a slave read is pending.
REQ-019 WRITE: m_cyc_o=m_stb_o=m_we_o=1 with FIFO head; on m_ack_i pop head, ->IDLE; on m_err_i pop head, set wrerr_o, ->IDLE; on m_rty_i ->WAIT.
REQ-020 READ: m_cyc_o=m_stb_o=1, m_we_o=0, slave adr/sel forwarded; on m_ack_i latch m_dat_i to s_dat_o, pulse s_ack_o next cycle, ->IDLE; m_err_i -> pulse s_err_o next cycle, ->IDLE; m_rty_i ->WAIT.
REQ-021 WAIT: strobes low for one cycle, then return to the retried state with identical request.
REQ-022 One master transfer in flight at most; ack/err/rty only honoured while m_stb_o high.
REQ-023 Read path round-trip: s_ack_o no earlier than 2 cycles after s_stb_i.
REQ-024 Slave drops s_stb_i before termination of a read: transfer completes on master side, s_ack_o suppressed.
REQ-025 FIFO pointers wrap modulo 2**DEPTH_BITS; count range 0..2**DEPTH_BITS.

Configuration
REQ-026 Macro WB_WRBUF_RTY_EN defined: write to full FIFO is terminated with a one-cycle s_rty_o (next cycle), no push; undefined: s_rty_o tied 0, stall per REQ-015.

Reset
REQ-027 wb_rst_i high immediately clears FIFO count/pointers, FSM to IDLE, and drives all outputs 0 (incl. wrerr_o, s_dat_o).
REQ-028 Reset mid-transfer discards buffered writes and the in-flight transfer; no termination is issued for them.
REQ-029 wrerr_o clears only on reset.

Structure
REQ-030 Shared package holds FSM state encoding and the FIFO entry field widths/offsets.
REQ-031 FIFO is one sub-module, wb_wrbuf_fifo (registered storage, push/pop/count/full/empty).

Verification
REQ-032 4 writes 0xA0..0xA3 with m_ack_i held low -> 4 s_ack_o pulses, 5th write stalls; release m_ack_i -> master sees A0..A3 in order, 5th write acked.
REQ-033 Write then read same address 0x100 -> master write to 0x100 completes before master read begins; s_dat_o=m_dat_i=0xDEADBEEF with s_ack_o.
REQ-034 m_rty_i on first master write attempt -> strobes low one cycle, identical write reissued, single pop.
REQ-035 m_err_i on a posted write -> wrerr_o=1 and stays 1 through later transfers until wb_rst_i.
REQ-036 wb_rst_i asserted with 3 entries buffered and m_stb_o high -> all outputs 0 same cycle, no master writes after release.
REQ-037 WB_WRBUF_RTY_EN defined, FIFO full, 5th write -> s_rty_o one-cycle pulse, count stays 4; undefined -> s_rty_o never 1.
